// File: rtl/pisa_mmio_pkg.sv
// Shared MMIO register map and UART transmitter state encoding for the PISA memory bridge.
// Declarations only: no logic, no latency.
// No flow control of its own; consumers decide how these encodings are used.
package pisa_mmio_pkg;

    // Register offsets inside the 256-byte MMIO page (word granular, low two bits ignored)
    localparam logic [7:0] MMIO_UART_DATA   = 8'h00;
    localparam logic [7:0] MMIO_UART_STATUS = 8'h04;
    localparam logic [7:0] MMIO_LED         = 8'h08;
    localparam logic [7:0] MMIO_CYCLE       = 8'h0C;

    // Bit positions in the UART_STATUS read value
    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_OVERFLOW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// UART transmit path: byte FIFO feeding an 8N1 serialiser, LSB first, idle high.
// A byte pushed into an empty, idle block reaches tx two cycles after the push cycle.
// Pushes while full are dropped here; the caller observes 'full' to flag the loss.
module uart_tx_fifo
    import pisa_mmio_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [7:0]     fifo_mem [2**AW];
    logic [AW:0]    wptr_q, wptr_d;
    logic [AW:0]    rptr_q, rptr_d;
    logic [AW:0]    count;
    logic           push_ok;
    logic           pop;

    uart_tx_state_t state_q, state_d;
    logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           tx_q, tx_d;
    logic           last_tick;
    logic           load;

    // Occupancy from the extra-bit pointers; full is judged before any same-cycle pop
    assign count   = wptr_q - rptr_q;
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign busy    = (state_q != IDLE);
    assign tx      = tx_q;

    assign last_tick = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));

    // FIFO storage write port; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wptr_q[AW-1:0]] <= push_data;
        end
    end

    // Serialiser next state: bit timing, shifting, and fetching the next byte
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                load = !empty;
            end
            START: begin
                if (last_tick) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = 3'd0;
                    tx_d      = shreg_q[0];
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (last_tick) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (last_tick) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                    // Back-to-back frames: the next start bit follows the stop bit directly
                    load      = !empty;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shreg_d   = fifo_mem[rptr_q[AW-1:0]];
            tx_d      = 1'b0;
            clk_cnt_d = '0;
            state_d   = START;
        end
    end

    assign pop = load;

    // Pointer updates
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    // State register; reset empties the FIFO and forces the line idle immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: rtl/pisa_mem_bridge.sv
// PISA core bus bridge: unaligned byte-addressed RAM plus an MMIO page (UART TX, LED, cycle counter).
// Reads are combinational (zero latency); writes commit on the clk edge where core_we is high.
// No backpressure to the core: UART_DATA writes to a full FIFO are dropped and set the overflow bit.
module pisa_mem_bridge
    import pisa_mmio_pkg::*;
#(
    parameter int          MEM_BYTES    = 4096,
    parameter logic [31:0] MMIO_BASE    = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_address,
    input  logic [31:0] core_wdata,
    input  logic        core_we,
    output logic [31:0] core_rdata,
    output logic        uart_tx,
    output logic [7:0]  led,
    output logic        uart_irq
);

    localparam int AW   = $clog2(MEM_BYTES);
    localparam int RW   = AW - 2;
    localparam int ROWS = MEM_BYTES / 4;

    logic        is_mmio;
    logic        is_ram;
    logic [7:0]  mmio_off;
    logic        ram_we;
    logic        mmio_we;
    logic        uart_push;
    logic [7:0]  lane_rd [4];
    logic [31:0] ram_rdata;
    logic [31:0] status;

    logic        fifo_full;
    logic        fifo_empty;
    logic        tx_busy;

    logic [7:0]  led_q, led_d;
    logic        ovf_q, ovf_d;
    logic [31:0] cycle_q, cycle_d;

    // MMIO wins over RAM; everything else is unmapped
    assign is_mmio   = (core_address >= MMIO_BASE);
    assign is_ram    = !is_mmio && (core_address < 32'(MEM_BYTES));
    assign mmio_off  = {core_address[7:2], 2'b00};
    assign ram_we    = core_we && is_ram;
    assign mmio_we   = core_we && is_mmio;
    assign uart_push = mmio_we && (mmio_off == MMIO_UART_DATA);

    // Four byte lanes. An access touches each lane exactly once; lanes below the
    // start lane belong to the next row, and the row index wraps at the top of RAM.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0]    mem [ROWS];
        logic          carry;
        logic [RW-1:0] row;
        logic [1:0]    src;

        assign carry      = (2'(l) < core_address[1:0]);
        assign row        = core_address[AW-1:2] + RW'(carry);
        assign src        = 2'(l) - core_address[1:0];
        assign lane_rd[l] = mem[row];

        // Lane write: takes the core_wdata byte whose address lands in this lane
        always_ff @(posedge clk) begin
            if (ram_we) begin
                mem[row] <= core_wdata[{src, 3'b000} +: 8];
            end
        end
    end

    // Little-endian reassembly: byte k of the word comes from lane (addr + k) mod 4
    for (genvar k = 0; k < 4; k++) begin : g_byte
        assign ram_rdata[8*k +: 8] = lane_rd[2'(k) + core_address[1:0]];
    end

    uart_tx_fifo #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (uart_push),
        .push_data (core_wdata[7:0]),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .busy      (tx_busy),
        .tx        (uart_tx)
    );

    // Register updates: LED load, sticky overflow set/clear, free-running cycle count
    always_comb begin
        led_d   = led_q;
        ovf_d   = ovf_q;
        cycle_d = cycle_q + 32'd1;
        if (mmio_we && (mmio_off == MMIO_LED)) begin
            led_d = core_wdata[7:0];
        end
        if (uart_push && fifo_full) begin
            ovf_d = 1'b1;
        end else if (mmio_we && (mmio_off == MMIO_UART_STATUS)) begin
            ovf_d = 1'b0;
        end
    end

    // MMIO register state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q   <= 8'h00;
            ovf_q   <= 1'b0;
            cycle_q <= 32'd0;
        end else begin
            led_q   <= led_d;
            ovf_q   <= ovf_d;
            cycle_q <= cycle_d;
        end
    end

    // UART_STATUS read value
    always_comb begin
        status                = 32'd0;
        status[STAT_EMPTY]    = fifo_empty;
        status[STAT_FULL]     = fifo_full;
        status[STAT_BUSY]     = tx_busy;
        status[STAT_OVERFLOW] = ovf_q;
    end

    // Combinational read mux across the three regions
    always_comb begin
        core_rdata = 32'd0;
        if (is_mmio) begin
            case (mmio_off)
                MMIO_UART_STATUS: core_rdata = status;
                MMIO_LED:         core_rdata = {24'd0, led_q};
                MMIO_CYCLE:       core_rdata = cycle_q;
                default:          core_rdata = 32'd0;
            endcase
        end else if (is_ram) begin
            core_rdata = ram_rdata;
        end
    end

    assign led      = led_q;
    assign uart_irq = fifo_empty && !tx_busy;

endmodule

// File: tb/tb_pisa_mem_bridge.sv
// Self-checking bench for pisa_mem_bridge: byte-level RAM model plus a frame-timeline UART model.
// Each cycle compares core_rdata, uart_tx, uart_irq and led against the model.
// Directed cases pin literal values; a randomized phase mixes RAM, MMIO and unmapped traffic.
module tb_pisa_mem_bridge;

    localparam int          MEM_BYTES  = 4096;
    localparam logic [31:0] MMIO_BASE  = 32'hFFFF_FF00;
    localparam int          FIFO_DEPTH = 8;
    localparam int          CPB        = 16;
    localparam int          FRAME      = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] core_address = MMIO_BASE + 32'h4;
    logic [31:0] core_wdata   = 32'h0;
    logic        core_we      = 1'b0;
    logic [31:0] core_rdata;
    logic        uart_tx;
    logic [7:0]  led;
    logic        uart_irq;

    pisa_mem_bridge #(
        .MEM_BYTES    (MEM_BYTES),
        .MMIO_BASE    (MMIO_BASE),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_address (core_address),
        .core_wdata   (core_wdata),
        .core_we      (core_we),
        .core_rdata   (core_rdata),
        .uart_tx      (uart_tx),
        .led          (led),
        .uart_irq     (uart_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  m_mem [MEM_BYTES];
    bit          m_known [MEM_BYTES];
    logic [7:0]  m_fifo [$];
    logic [7:0]  m_cur;
    int          m_el;      // cycles into the current frame, -1 when the line is idle
    bit          m_ovf;
    logic [7:0]  m_led;
    logic [31:0] m_cnt;
    logic [31:0] last_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t addr=%h: got %h expected %h", nm, $time, core_address, act, exp);
        end
    endtask

    function automatic void m_reset();
        m_fifo.delete();
        m_el  = -1;
        m_ovf = 1'b0;
        m_led = 8'h00;
        m_cnt = 32'd0;
    endfunction

    function automatic logic [31:0] m_status();
        return {28'd0, m_ovf, (m_el >= 0), (m_fifo.size() == FIFO_DEPTH), (m_fifo.size() == 0)};
    endfunction

    // Line level as a function of position in the 10-bit 8N1 frame
    function automatic logic m_tx();
        int idx;
        if (m_el < 0) return 1'b1;
        idx = m_el / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    function automatic void m_read(input logic [31:0] a, output logic [31:0] v, output logic [31:0] mask);
        int ba;
        v    = 32'd0;
        mask = 32'hFFFF_FFFF;
        if (a >= MMIO_BASE) begin
            case (a[7:2])
                6'd1:    v = m_status();
                6'd2:    v = {24'd0, m_led};
                6'd3:    v = m_cnt;
                default: v = 32'd0;
            endcase
        end else if (a < MEM_BYTES) begin
            for (int k = 0; k < 4; k++) begin
                ba = int'((a + 32'(k)) % 32'(MEM_BYTES));
                v[8*k +: 8] = m_mem[ba];
                if (!m_known[ba]) mask[8*k +: 8] = 8'h00;
            end
        end
    endfunction

    // Advance the model across one clock edge using the pre-edge state
    function automatic void m_step(input logic [31:0] a, input logic [31:0] d, input logic w);
        bit full_b;
        int ba;
        full_b = (m_fifo.size() == FIFO_DEPTH);
        if ((m_el < 0 || m_el == FRAME - 1) && m_fifo.size() != 0) begin
            m_cur = m_fifo.pop_front();
            m_el  = 0;
        end else if (m_el == FRAME - 1) begin
            m_el = -1;
        end else if (m_el >= 0) begin
            m_el++;
        end
        if (w) begin
            if (a >= MMIO_BASE) begin
                case (a[7:2])
                    6'd0: if (full_b) m_ovf = 1'b1; else m_fifo.push_back(d[7:0]);
                    6'd1: m_ovf = 1'b0;
                    6'd2: m_led = d[7:0];
                    default: ;
                endcase
            end else if (a < MEM_BYTES) begin
                for (int k = 0; k < 4; k++) begin
                    ba = int'((a + 32'(k)) % 32'(MEM_BYTES));
                    m_mem[ba]   = d[8*k +: 8];
                    m_known[ba] = 1'b1;
                end
            end
        end
        m_cnt = m_cnt + 32'd1;
    endfunction

    // One bus cycle: drive, compare all outputs against the model, clock, update the model
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input bit lit_en = 1'b0, input logic [31:0] lit = 32'h0, input string nm = "");
        logic [31:0] ev, em;
        core_address = a;
        core_wdata   = d;
        core_we      = w;
        #1;
        m_read(a, ev, em);
        last_rdata = core_rdata;
        chk("rdata", core_rdata & em, ev & em);
        chk("uart_tx", {31'd0, uart_tx}, {31'd0, m_tx()});
        chk("uart_irq", {31'd0, uart_irq}, {31'd0, (m_fifo.size() == 0 && m_el < 0)});
        chk("led", {24'd0, led}, {24'd0, m_led});
        if (lit_en) chk(nm, core_rdata, lit);
        @(posedge clk);
        m_step(a, d, w);
        @(negedge clk);
    endtask

    initial begin
        int          sel;
        logic [31:0] ra;
        logic        rw;
        logic [31:0] c1;

        m_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'h1);
        chk("rst_uart_irq", {31'd0, uart_irq}, 32'h1);
        chk("rst_led", {24'd0, led}, 32'h0);
        chk("rst_status", core_rdata, 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Fill RAM so every later read is fully comparable
        for (int i = 0; i < MEM_BYTES / 4; i++) cyc(32'(i * 4), $urandom, 1'b1);

        // Unaligned reads
        cyc(32'h100, 32'h4433_2211, 1'b1);
        cyc(32'h104, 32'h8877_6655, 1'b1);
        cyc(32'h108, 32'hCCBB_AA99, 1'b1);
        cyc(32'h102, 32'h0, 1'b0, 1'b1, 32'h6655_4433, "unaligned_102");
        cyc(32'h107, 32'h0, 1'b0, 1'b1, 32'hBBAA_9988, "unaligned_107");

        // Wrap across the top of RAM
        cyc(32'h2, 32'h0000_7766, 1'b1);
        cyc(32'(MEM_BYTES - 2), 32'hDDCC_BBAA, 1'b1);
        cyc(32'(MEM_BYTES - 2), 32'h0, 1'b0, 1'b1, 32'hDDCC_BBAA, "wrap_read");
        cyc(32'h0, 32'h0, 1'b0, 1'b1, 32'h7766_DDCC, "wrap_low");

        // Single UART frame of 0x55
        cyc(MMIO_BASE, 32'h55, 1'b1);
        for (int i = 0; i < 170; i++) begin
            if (i == 25)  chk("frame_bit0", {31'd0, uart_tx}, 32'h1);
            if (i == 41)  chk("frame_bit1", {31'd0, uart_tx}, 32'h0);
            if (i == 150) chk("frame_stop", {31'd0, uart_tx}, 32'h1);
            if (i == 165) chk("frame_irq", {31'd0, uart_irq}, 32'h1);
            cyc(MMIO_BASE + 32'h4, 32'h0, 1'b0, (i == 0 || i == 10 || i == 165),
                (i == 0) ? 32'h0 : (i == 10) ? 32'h5 : 32'h1, "frame_status");
        end

        // Overflow: transmitter busy, 8 bytes fill the FIFO, the 9th is dropped
        cyc(MMIO_BASE, $urandom, 1'b1);
        repeat (3) cyc(MMIO_BASE + 32'h4, 32'h0, 1'b0);
        for (int j = 0; j < 9; j++) cyc(MMIO_BASE, $urandom, 1'b1);
        cyc(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 32'h0000_000E, "status_ovf");
        cyc(MMIO_BASE + 32'h4, $urandom, 1'b1);
        cyc(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 32'h0000_0006, "status_ovf_clr");
        for (int i = 0; i < 9 * FRAME + 20; i++) cyc(MMIO_BASE + 32'h4, 32'h0, 1'b0);
        cyc(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 32'h1, "status_drained");

        // LED, CYCLE, unmapped
        cyc(MMIO_BASE + 32'h8, 32'h1234_56A5, 1'b1);
        chk("led_out", {24'd0, led}, 32'hA5);
        cyc(MMIO_BASE + 32'h8, 32'h0, 1'b0, 1'b1, 32'hA5, "led_read");
        cyc(MMIO_BASE + 32'hB, 32'h0, 1'b0, 1'b1, 32'hA5, "led_read_misaligned");
        cyc(MMIO_BASE + 32'hC, 32'h0, 1'b0);
        c1 = last_rdata;
        for (int i = 0; i < 37; i++) cyc(MMIO_BASE + 32'hC, 32'hFFFF_0000, (i == 5));
        chk("cycle_delta", last_rdata - c1, 32'd37);
        cyc(32'h8000_0000, 32'h0, 1'b0, 1'b1, 32'h0, "unmapped_rd");
        cyc(32'h8000_0000, 32'hDEAD_BEEF, 1'b1);
        cyc(32'h8000_0000, 32'h0, 1'b0, 1'b1, 32'h0, "unmapped_rd2");
        cyc(32'h0, 32'h0, 1'b0, 1'b1, 32'h7766_DDCC, "unmapped_wr_ram");
        cyc(32'(MEM_BYTES), 32'h0, 1'b0, 1'b1, 32'h0, "above_ram");
        cyc(MMIO_BASE - 32'h1, 32'h0, 1'b0, 1'b1, 32'h0, "below_mmio");
        cyc(MMIO_BASE + 32'h40, 32'h0, 1'b0, 1'b1, 32'h0, "mmio_hole");

        // Randomized mixed traffic
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 9));
            rw  = ($urandom_range(0, 3) == 0);
            if (sel <= 5)      ra = $urandom_range(0, MEM_BYTES - 1);
            else if (sel <= 7) ra = MMIO_BASE + $urandom_range(0, 255);
            else if (sel == 8) ra = MMIO_BASE + $urandom_range(0, 15);
            else               ra = $urandom_range(MEM_BYTES - 2, MEM_BYTES + 2) +
                                    (($urandom_range(0, 1) == 1) ? (MMIO_BASE - 32'(MEM_BYTES)) : 32'h0);
            cyc(ra, $urandom, rw);
        end

        // Drain, then reset in the middle of a frame
        for (int i = 0; i < 20000 && (m_el >= 0 || m_fifo.size() != 0); i++)
            cyc(MMIO_BASE + 32'h4, 32'h0, 1'b0);
        cyc(MMIO_BASE, 32'hA3, 1'b1);
        cyc(MMIO_BASE, 32'h5C, 1'b1);
        for (int i = 0; i < 72; i++) cyc(MMIO_BASE + 32'h4, 32'h0, 1'b0);
        chk("tx_data_bit3", {31'd0, uart_tx}, 32'h0);
        core_we = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("tx_async_rst", {31'd0, uart_tx}, 32'h1);
        m_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(MMIO_BASE + 32'h4, 32'h0, 1'b0, 1'b1, 32'h1, "status_after_rst");
        for (int i = 0; i < 200; i++) cyc(MMIO_BASE + 32'h4, 32'h0, 1'b0);
        chk("irq_after_rst", {31'd0, uart_irq}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
